// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and the round-robin selection helpers for the packet arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_STREAMS = 32;
    localparam int unsigned IDX_W       = $clog2(MAX_STREAMS);

    // First set bit of req at or above ptr, wrapping at n-1 -> 0; one-hot result.
    function automatic logic [MAX_STREAMS-1:0] rr_select(
        input logic [MAX_STREAMS-1:0] req,
        input int unsigned            ptr,
        input int unsigned            n
    );
        logic [MAX_STREAMS-1:0] sel;
        logic                   found;
        int unsigned            idx;
        logic [IDX_W-1:0]       idx_w;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_STREAMS; i++) begin
            idx = ptr + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            idx_w = idx[IDX_W-1:0];
            if ((i < n) && !found && req[idx_w]) begin
                sel[idx_w] = 1'b1;
                found      = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_index(input logic [MAX_STREAMS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_STREAMS; i++) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_register.sv
// Single-stage registered AXI-Stream slice; accepts a new beat whenever it is
// empty or its current beat is being drained in the same cycle.
module axis_register #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              sreset,
    input  logic              up_tvalid,
    output logic              up_tready,
    input  logic              up_tlast,
    input  logic [DATA_W-1:0] up_tdata,
    output logic              dn_tvalid,
    input  logic              dn_tready,
    output logic              dn_tlast,
    output logic [DATA_W-1:0] dn_tdata
);

    logic              valid_reg;
    logic              last_reg;
    logic [DATA_W-1:0] data_reg;

    assign up_tready = !valid_reg || dn_tready;

    always_ff @(posedge clk) begin
        if (sreset) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            data_reg  <= '0;
        end else if (up_tvalid && up_tready) begin
            valid_reg <= 1'b1;
            last_reg  <= up_tlast;
            data_reg  <= up_tdata;
        end else if (dn_tready) begin
            valid_reg <= 1'b0;
        end
    end

    assign dn_tvalid = valid_reg;
    assign dn_tlast  = last_reg;
    assign dn_tdata  = data_reg;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin merge of several AXI-Stream inputs onto one
// registered output; a grant is held from first beat until tlast is accepted.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int AXIS_BYTES        = 1,
    parameter int NUM_SLAVE_STREAMS = 2
) (
    input  logic                                    clk,
    input  logic                                    sreset,
    output logic [NUM_SLAVE_STREAMS-1:0]            axis_i_tready,
    input  logic [NUM_SLAVE_STREAMS-1:0]            axis_i_tvalid,
    input  logic [NUM_SLAVE_STREAMS-1:0]            axis_i_tlast,
    input  logic [NUM_SLAVE_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,
    input  logic                                    axis_o_tready,
    output logic                                    axis_o_tvalid,
    output logic                                    axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]                 axis_o_tdata,
    output logic [NUM_SLAVE_STREAMS-1:0]            grant
);

    localparam int unsigned N     = NUM_SLAVE_STREAMS;
    localparam int unsigned DW    = AXIS_BYTES * 8;
    localparam int unsigned PTR_W = $clog2(N);

    arb_state_t             state_reg, state_next;
    logic [PTR_W-1:0]       ptr_reg, ptr_next;
    logic [PTR_W-1:0]       gidx_reg, gidx_next;
    logic [N-1:0]           grant_reg, grant_next;
    logic [MAX_STREAMS-1:0] pick;
    logic [DW-1:0]          data_arr [N];
    logic [DW-1:0]          sel_data;
    logic                   sel_valid, sel_last;
    logic                   slice_ready, in_ready, accept;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_split
            assign data_arr[gi] = axis_i_tdata[gi*DW +: DW];
        end
    endgenerate

    // Ready depends only on registered state and the output slice, never on tvalid.
    assign in_ready      = (state_reg == PASS) && slice_ready;
    assign axis_i_tready = in_ready ? grant_reg : '0;
    assign sel_valid     = (state_reg == PASS) && axis_i_tvalid[gidx_reg];
    assign sel_last      = axis_i_tlast[gidx_reg];
    assign sel_data      = data_arr[gidx_reg];
    assign accept        = sel_valid && slice_ready;
    assign pick          = rr_select(MAX_STREAMS'(axis_i_tvalid), 32'(ptr_reg), N);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        gidx_next  = gidx_reg;
        grant_next = grant_reg;
        case (state_reg)
            IDLE: begin
                if (|axis_i_tvalid) begin
                    grant_next = pick[N-1:0];
                    gidx_next  = PTR_W'(onehot_index(pick));
                    state_next = PASS;
                end
            end
            PASS: begin
                if (accept && sel_last) begin
                    // Explicit wrap so non-power-of-two stream counts behave.
                    ptr_next   = (gidx_reg == PTR_W'(N - 1)) ? '0 : gidx_reg + 1'b1;
                    grant_next = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            gidx_reg  <= '0;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            gidx_reg  <= gidx_next;
            grant_reg <= grant_next;
        end
    end

    assign grant = grant_reg;

    axis_register #(
        .DATA_W (DW)
    ) u_out_slice (
        .clk       (clk),
        .sreset    (sreset),
        .up_tvalid (sel_valid),
        .up_tready (slice_ready),
        .up_tlast  (sel_last),
        .up_tdata  (sel_data),
        .dn_tvalid (axis_o_tvalid),
        .dn_tready (axis_o_tready),
        .dn_tlast  (axis_o_tlast),
        .dn_tdata  (axis_o_tdata)
    );

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter: a queue-driven source feeds the
// N=2 instance, a monitor pops expected beats; an N=3 instance checks wrap.
module tb_axis_packet_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] hold;
    } beat_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk    = 1'b0;
    logic        sreset = 1'b1;

    logic [1:0]  i_vld  = '0;
    logic [1:0]  i_last = '0;
    logic [15:0] i_data = '0;
    logic [1:0]  i_rdy;
    logic        o_rdy  = 1'b1;
    logic        o_vld, o_last;
    logic [7:0]  o_data;
    logic [1:0]  grant;

    logic [2:0]  i3_vld  = '0;
    logic [2:0]  i3_last = '0;
    logic [23:0] i3_data = '0;
    logic [2:0]  i3_rdy;
    logic        o3_rdy  = 1'b1;
    logic        o3_vld, o3_last;
    logic [7:0]  o3_data;
    logic [2:0]  grant3;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          n_pop = 0;
    logic        force_all = 1'b1;
    logic        bp_mode   = 1'b0;

    beat_t       src_q [2][$];
    exp_t        exp_q [$];
    int          out_cyc [$];

    axis_packet_arbiter #(
        .AXIS_BYTES        (1),
        .NUM_SLAVE_STREAMS (2)
    ) dut (
        .clk           (clk),
        .sreset        (sreset),
        .axis_i_tready (i_rdy),
        .axis_i_tvalid (i_vld),
        .axis_i_tlast  (i_last),
        .axis_i_tdata  (i_data),
        .axis_o_tready (o_rdy),
        .axis_o_tvalid (o_vld),
        .axis_o_tlast  (o_last),
        .axis_o_tdata  (o_data),
        .grant         (grant)
    );

    axis_packet_arbiter #(
        .AXIS_BYTES        (1),
        .NUM_SLAVE_STREAMS (3)
    ) dut3 (
        .clk           (clk),
        .sreset        (sreset),
        .axis_i_tready (i3_rdy),
        .axis_i_tvalid (i3_vld),
        .axis_i_tlast  (i3_last),
        .axis_i_tdata  (i3_data),
        .axis_o_tready (o3_rdy),
        .axis_o_tvalid (o3_vld),
        .axis_o_tlast  (o3_last),
        .axis_o_tdata  (o3_data),
        .grant         (grant3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Source: presents queued beats, honours per-beat idle gaps, drives o_rdy.
    initial begin : source
        logic [1:0] acc;
        beat_t      b;
        int         bp_cnt;
        bp_cnt = 0;
        forever begin
            @(negedge clk);
            acc = i_vld & i_rdy;
            @(posedge clk);
            #1;
            if (bp_mode) begin
                o_rdy  = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
                bp_cnt = bp_cnt + 1;
            end else begin
                o_rdy = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                if (acc[k] && src_q[k].size() > 0) begin
                    void'(src_q[k].pop_front());
                end
                if (force_all) begin
                    i_vld[k]  = 1'b1;
                    i_last[k] = 1'b0;
                end else if (src_q[k].size() == 0) begin
                    i_vld[k]  = 1'b0;
                    i_last[k] = 1'b0;
                end else if (src_q[k][0].hold != 8'd0) begin
                    b      = src_q[k].pop_front();
                    b.hold = b.hold - 8'd1;
                    src_q[k].push_front(b);
                    i_vld[k] = 1'b0;
                end else begin
                    i_vld[k]         = 1'b1;
                    i_last[k]        = src_q[k][0].last;
                    i_data[k*8 +: 8] = src_q[k][0].data;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each output handshake, checks stall stability.
    initial begin : monitor
        exp_t       e;
        logic       stalled;
        logic [7:0] st_data;
        logic       st_last;
        stalled = 1'b0;
        st_data = '0;
        st_last = 1'b0;
        forever begin
            @(negedge clk);
            if (stalled && !sreset) begin
                total++;
                if (!o_vld || o_data != st_data || o_last != st_last) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                             o_vld, o_data, o_last, st_data, st_last);
                end
            end
            stalled = o_vld && !o_rdy;
            st_data = o_data;
            st_last = o_last;
            if (o_vld && o_rdy) begin
                n_pop++;
                out_cyc.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat: got d=%h l=%b, want no beat", o_data, o_last);
                end else begin
                    e = exp_q.pop_front();
                    if (o_data != e.data || o_last != e.last) begin
                        bad++;
                        $display("FAIL beat: got d=%h l=%b, want d=%h l=%b",
                                 o_data, o_last, e.data, e.last);
                    end else begin
                        $display("beat d=%h l=%b cycle=%0d", o_data, o_last, cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end else begin
            $display("check %s = %0h", name, got);
        end
    endtask

    task automatic send(input int k, input logic [7:0] data, input logic last, input logic [7:0] hold);
        beat_t b;
        exp_t  e;
        b.data = data;
        b.last = last;
        b.hold = hold;
        src_q[k].push_back(b);
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 || o_vld)
               && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(n < 300), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int         base;
        int         found;
        logic [2:0] g3_q [$];
        logic [7:0] d3_q [$];

        // Reset with every input valid.
        i3_vld  = 3'b111;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_o_vld", 32'(o_vld), 32'd0);
            check("rst_o_data", 32'(o_data), 32'd0);
            check("rst_grant", 32'(grant), 32'd0);
            check("rst_i_rdy", 32'(i_rdy), 32'd0);
            check("rst_grant3", 32'(grant3), 32'd0);
            if (c == 2) force_all = 1'b0;
        end
        @(posedge clk);
        #1;
        sreset = 1'b0;
        i3_vld = '0;
        repeat (2) @(negedge clk);

        // Fairness: two 3-beat packets per stream, alternating order.
        base = out_cyc.size();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 2; k++) begin
                for (int b = 0; b < 3; b++) begin
                    send(k, 8'(16 * (k + 1) + b), b == 2, 8'd0);
                end
            end
        end
        drain("fair");
        check("fair_beats", 32'(out_cyc.size() - base), 32'd12);
        if (out_cyc.size() >= base + 12) begin
            check("fair_contig", 32'(out_cyc[base+1] - out_cyc[base]), 32'd1);
            check("fair_bubble1", 32'(out_cyc[base+3] - out_cyc[base+2]), 32'd2);
            check("fair_bubble2", 32'(out_cyc[base+6] - out_cyc[base+5]), 32'd2);
        end

        // No interleave: stream0 pauses 4 cycles mid-packet while stream1 waits.
        send(0, 8'h30, 1'b0, 8'd0);
        send(0, 8'h31, 1'b0, 8'd4);
        send(0, 8'h32, 1'b1, 8'd0);
        send(1, 8'h40, 1'b1, 8'd0);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (grant != 2'b00 && !i_vld[0]) found = 1;
        end
        check("hold_seen", 32'(found), 32'd1);
        for (int c = 0; c < 4; c++) begin
            check("hold_grant", 32'(grant), 32'b01);
            check("hold_rdy1", 32'(i_rdy[1]), 32'd0);
            @(negedge clk);
        end
        drain("hold");

        // Backpressure: o_rdy follows 1,0,0,1 during a 4-beat packet.
        base    = n_pop;
        bp_mode = 1'b1;
        for (int b = 0; b < 4; b++) begin
            send(0, 8'(8'h50 + b), b == 3, 8'd0);
        end
        drain("bp");
        bp_mode = 1'b0;
        check("bp_count", 32'(n_pop - base), 32'd4);

        // Wrap on the 3-stream instance: stream2 first, then streams 2 and 0.
        @(posedge clk);
        #1;
        i3_vld  = 3'b100;
        i3_last = 3'b111;
        i3_data = 24'h0A0B0C;
        @(posedge clk);
        #1;
        i3_vld = 3'b101;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (grant3 != 3'b000) g3_q.push_back(grant3);
            if (o3_vld) d3_q.push_back(o3_data);
        end
        i3_vld = '0;
        check("wrap_ngrants", 32'(g3_q.size() >= 3), 32'd1);
        check("wrap_ndata", 32'(d3_q.size() >= 2), 32'd1);
        if (g3_q.size() >= 3) begin
            check("wrap_g0", 32'(g3_q[0]), 32'b100);
            check("wrap_g1", 32'(g3_q[1]), 32'b001);
            check("wrap_g2", 32'(g3_q[2]), 32'b100);
        end
        if (d3_q.size() >= 2) begin
            check("wrap_d0", 32'(d3_q[0]), 32'h0A);
            check("wrap_d1", 32'(d3_q[1]), 32'h0C);
        end
        repeat (3) @(negedge clk);

        // Reset after the second beat of a 5-beat packet on stream1.
        for (int b = 0; b < 5; b++) begin
            beat_t bt;
            bt.data = 8'(8'h60 + b);
            bt.last = (b == 4);
            bt.hold = 8'd0;
            src_q[1].push_back(bt);
        end
        exp_q.push_back('{data: 8'h60, last: 1'b0});
        exp_q.push_back('{data: 8'h61, last: 1'b0});
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(negedge clk);
            if (i_vld[1] && i_rdy[1] && i_data[15:8] == 8'h61) found = 1;
        end
        check("rstmid_seen", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        sreset = 1'b1;
        @(negedge clk);
        src_q[0].delete();
        src_q[1].delete();
        @(negedge clk);
        check("rstmid_o_vld", 32'(o_vld), 32'd0);
        check("rstmid_o_last", 32'(o_last), 32'd0);
        check("rstmid_grant", 32'(grant), 32'd0);
        check("rstmid_exp_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        sreset = 1'b0;
        @(negedge clk);
        send(0, 8'h70, 1'b1, 8'd0);
        send(1, 8'h80, 1'b1, 8'd0);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (grant != 2'b00) found = 1;
        end
        check("rstmid_first_grant", 32'(grant), 32'b01);
        drain("rstmid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Round-robin, packet-granular arbiter merging NUM_SLAVE_STREAMS AXI-Stream inputs onto one AXI-Stream output; the counterpart of the round-robin splitter used on the receive side. A grant is held from the first beat of a packet until its tlast beat is accepted, so packets are never interleaved. The output is registered, which breaks the tvalid/tdata timing path into the downstream sink.

## Interface
Parameters:
- AXIS_BYTES, 1, output and per-input tdata width in bytes.
- NUM_SLAVE_STREAMS, 2, number of input streams (N ≥ 2).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- sreset  in  1  synchronous, active-high reset.
- axis_i_tready  out  N  per-input ready; bit k belongs to stream k.
- axis_i_tvalid  in  N  per-input valid.
- axis_i_tlast  in  N  per-input last.
- axis_i_tdata  in  N*AXIS_BYTES*8  stream k occupies bits [(k+1)*AXIS_BYTES*8-1 : k*AXIS_BYTES*8].
- axis_o_tready  in  1  output ready.
- axis_o_tvalid  out  1  output valid, registered.
- axis_o_tlast  out  1  output last, registered.
- axis_o_tdata  out  AXIS_BYTES*8  output data, registered.
- grant  out  N  one-hot currently granted stream; all zero when IDLE.

## Operation
- State machine, two states:
  - IDLE: if any axis_i_tvalid is set, select the first set bit scanning upward from pointer `ptr`, wrapping at N-1 → 0. Register it into `grant` and go to PASS. If no bit is set, stay in IDLE. All axis_i_tready are 0 in IDLE.
  - PASS: axis_i_tready[g] = (!axis_o_tvalid || axis_o_tready) for the granted g; every other bit is 0. On an accepted beat with tlast=1: `ptr` ← (g+1) mod N, `grant` ← 0, next state IDLE.
- The grant is held when the granted stream deasserts tvalid mid-packet. Other requesters wait; there is no timeout.
- Output register: loads tdata/tlast and sets axis_o_tvalid on each accepted input beat. It clears axis_o_tvalid when axis_o_tready is high and no new beat loads. Load and drain in the same cycle is allowed, giving full throughput.
- Output signals never change while axis_o_tvalid=1 and axis_o_tready=0.
- `ptr` width: $clog2(N); the wrap is explicit and also correct for non-power-of-two N.

## Timing
- Reset values: axis_o_tvalid=0, axis_o_tlast=0, axis_o_tdata=0, grant=0, axis_i_tready=0, state=IDLE, ptr=0.
- Arbitration: one cycle. With a request present in IDLE at cycle t, grant is visible at t+1 and the first beat can be accepted at t+1.
- Data latency: an input beat accepted at cycle t appears on the output at t+1.
- Inter-packet bubble: exactly one cycle (the IDLE cycle) between the tlast beat of one packet and the first beat of the next, including back-to-back packets on the same stream.
- Single-beat packet (tlast on the first beat): the arbiter is in PASS for one cycle and returns to IDLE.
- Single active requester: it is re-granted every packet, with one bubble between packets.
- sreset asserted mid-packet: all state returns to reset values on the next edge. The partial packet is dropped at the output, with no tlast emitted. ptr returns to 0.
- axis_i_tready is combinational from axis_o_tready and the registered state only; it never depends on axis_i_tvalid.

## Structure
- Package axis_arb_pkg: state enum (IDLE, PASS); function rr_select(req, ptr) returning a one-hot result, parameterised by N via an unpacked-width argument or a class-free parameterised function wrapper.
- Sub-module axis_register: a single-stage registered AXI-Stream slice (tdata/tlast/tvalid regs, ready = !valid || o_ready). It is reusable elsewhere; the arbiter instantiates it on the merged stream.

## Test plan
- Reset: hold sreset 3 cycles with all inputs valid → all outputs 0, grant=0, axis_i_tready=0 throughout.
- Fairness: N=2, both streams continuously offer 3-beat packets (stream0 data 0x10..0x12, stream1 0x20..0x22), axis_o_tready=1 → output order 10,11,12,20,21,22,10,…; tlast on every third beat; one bubble between packets.
- No interleave: stream1 offers while stream0 holds tvalid low mid-packet for 4 cycles → grant stays 01, stream1 ready stays 0, stream0 packet completes contiguously at the output.
- Backpressure: axis_o_tready toggles 1,0,0,1 during a 4-beat packet → no beat lost or duplicated, output stable during stalls, final count 4 beats.
- Wrap with N=3: only streams 2 and 0 request → grants alternate 100, 001, 100; ptr wraps 2→0.
- Reset mid-packet: assert sreset after beat 2 of 5 → axis_o_tvalid=0 next cycle; after release, the first grant goes to the lowest-index requester.
